dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the pipeline's data-memory port. It is the slave that the MEM stage drives with MemRead/MemWrite, byte address and store data. It adds a configurable number of wait states, signalled back to the CPU as `stall`, and stores data in a word-addressed array. It also decodes one memory-mapped LED register and flags misaligned or out-of-range accesses.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words in the array; must be a power of two, at most 256.
- `WAIT`, 2: wait states per access, range 0..7.
- `LED_ADDR`, 32'h0000_0100: byte address of the LED register.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data; valid only in the completion cycle.
- `stall`  out  1  1 = hold the request, the access is not complete.
- `led`  out  16  LED register, `wdata[15:0]` of the last store to `LED_ADDR`.
- `err`  out  1  sticky: a misaligned or out-of-range access has occurred.
- `err_addr`  out  32  `addr` of the first faulting access.

## Operation
- The request is `req = mem_read | mem_write`. If both are 1, the access is a store.
- The requester holds `mem_read`, `mem_write`, `addr` and `wdata` stable while `stall` = 1. When `stall` = 0 in a cycle with `req` = 1, that cycle is the completion cycle.
- FSM states, with a 3-bit counter `cnt`:
  - IDLE: `stall = req & (WAIT != 0)`.
    - `req` and `WAIT` = 0: the access completes in this cycle; stay in IDLE.
    - `req` and `WAIT` > 0: go to BUSY with `cnt = WAIT-1`.
  - BUSY: `stall = (cnt != 0)`.
    - `cnt != 0`: decrement `cnt`.
    - `cnt == 0`: completion cycle; return to IDLE.
- Completion cycle actions, by address decode:
  - Aligned, word index `addr[31:2] < DEPTH`: a store writes `wdata` at the clock edge; a load drives `rdata` = array word, combinationally.
  - `addr == LED_ADDR`: a store loads `led <= wdata[15:0]`; a load returns `{16'b0, led}`.
  - `addr[1:0] != 0`, or out of range and not `LED_ADDR`: no state change except the fault. `rdata` = 0. If `err` was 0, set `err` and capture `err_addr`.
- `rdata` = 0 in every cycle that is not a load completion.
- A store followed by a load of the same word returns the new data.
- A store and a load completing in the same cycle as an `rst` assertion are discarded.

## Timing
- Every request is held for `WAIT+1` cycles with `stall` high for exactly `WAIT` of them. There is no idle bubble between back-to-back requests.
- A request seen in IDLE the cycle after a completion is a new access.
- `stall` depends combinationally on `req`. There is no combinational path from `addr` or `wdata` to `stall`.
- Reset values: FSM = IDLE, `cnt` = 0, `led` = 0, `err` = 0, `err_addr` = 0. `stall` = 0 and `rdata` = 0 while `req` = 0. Array contents are not reset.
- Reset asserted mid-access: the FSM returns to IDLE at once and the pending store is dropped. After deassertion, a still-held request restarts its full wait count.
- `req` dropping while in BUSY is a protocol violation. The block must still return to IDLE when `cnt` reaches 0, with no write.

## Structure
- Shared package `dmem_pkg`: state enum (IDLE, BUSY), `LED_ADDR` default, and a `WORD_W = 32` constant.
- Natural sub-module: `dmem_wait_ctr`, the loadable down-counter with a zero flag. The array and address decode stay in the top level.

## Test plan
- `WAIT` = 2, store 32'hDEAD_BEEF to 0x10 -> `stall` = 1,1,0 over 3 cycles; a following load of 0x10 returns 32'hDEAD_BEEF in its 3rd cycle with `stall` = 0.
- `WAIT` = 0, back-to-back store 0x4 = 5, then load 0x4 -> `stall` never 1; `rdata` = 5 in the load cycle.
- Store 32'h0001_ABCD to 0x100, then load 0x100 -> `led` = 16'hABCD after the edge; load returns 32'h0000_ABCD.
- Load 0x6 (misaligned), then store to 0x400 (out of range, `DEPTH` = 64) -> `rdata` = 0; `err` = 1; `err_addr` = 0x6 and unchanged by the second fault; array unchanged.
- `mem_read` = `mem_write` = 1, address 0x8, old word 7, `wdata` 9 -> store performed; `rdata` = 0; later load returns 9.
- `rst` low in BUSY with `cnt` = 1 during a store of 0xFF to 0x20 -> FSM IDLE, `led` = 0, `err` = 0; word 0x20 keeps its old value; the held request then takes the full `WAIT+1` cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] LED_ADDR_DEFAULT = 32'h0000_0100;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data-memory port between the CPU and the responder
interface dmem_responder_if;
    import dmem_pkg::*;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              stall;
    logic [15:0]       led;
    logic              err;
    logic [WORD_W-1:0] err_addr;
    modport master (output mem_read, mem_write, addr, wdata,
                    input  rdata, stall, led, err, err_addr);
    modport slave  (input  mem_read, mem_write, addr, wdata,
                    output rdata, stall, led, err, err_addr);
endinterface

// File: rtl/dmem_wait_ctr.sv
// dmem_wait_ctr: loadable 3-bit down-counter counting the remaining wait states
module dmem_wait_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [2:0] i_val,
    input  logic       i_dec,
    output logic       o_zero
);
    logic [2:0] r_cnt;
    // load takes priority; decrement only while wait states remain
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec)
            r_cnt <= r_cnt - 3'd1;
    assign o_zero = (r_cnt == 3'd0);
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word memory with an LED register and sticky fault capture
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                DEPTH    = 64,
    parameter int                WAIT     = 2,
    parameter logic [WORD_W-1:0] LED_ADDR = LED_ADDR_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    dmem_responder_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] W_LOAD = 3'((WAIT > 0) ? WAIT - 1 : 0);
    localparam logic HAS_WAIT = (WAIT != 0);

    state_t            r_state;
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [15:0]       r_led;
    logic              r_err;
    logic [WORD_W-1:0] r_err_addr;

    logic          w_req, w_store, w_stall, w_done, w_hit, w_is_led, w_fault;
    logic          w_load_ctr, w_dec, w_zero;
    logic [AW-1:0] w_idx;

    assign w_req      = bus.mem_read | bus.mem_write;
    assign w_store    = bus.mem_write;
    assign w_stall    = (r_state == IDLE) ? (w_req & HAS_WAIT) : !w_zero;
    // a completion while reset is held is discarded
    assign w_done     = w_req & !w_stall & rst;
    assign w_hit      = (bus.addr[1:0] == 2'b00) && (bus.addr[31:2] < 30'(DEPTH));
    assign w_is_led   = !w_hit && (bus.addr == LED_ADDR);
    assign w_fault    = !w_hit && !w_is_led;
    assign w_idx      = bus.addr[AW+1:2];
    assign w_load_ctr = (r_state == IDLE) & w_req & HAS_WAIT;
    assign w_dec      = (r_state == BUSY) & !w_zero;

    dmem_wait_ctr u_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load_ctr),
        .i_val  (W_LOAD),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    // BUSY runs until the counter drains, even if the request was dropped
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_state <= IDLE;
        else if (w_load_ctr)
            r_state <= BUSY;
        else if (r_state == BUSY && w_zero)
            r_state <= IDLE;

    // array write on a completing store to an in-range aligned word
    always_ff @(posedge clk)
        if (w_done && w_store && w_hit)
            r_mem[w_idx] <= bus.wdata;

    // LED register and first-fault capture
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_led      <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_done) begin
            if (w_is_led && w_store)
                r_led <= bus.wdata[15:0];
            if (w_fault && !r_err) begin
                r_err      <= 1'b1;
                r_err_addr <= bus.addr;
            end
        end

    assign bus.stall    = w_stall;
    assign bus.rdata    = (w_done && !w_store) ?
                          (w_hit ? r_mem[w_idx] : w_is_led ? {16'h0, r_led} : '0) : '0;
    assign bus.led      = r_led;
    assign bus.err      = r_err;
    assign bus.err_addr = r_err_addr;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a behavioural model
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if b2 ();
    dmem_responder_if b0 ();

    dmem_responder #(.DEPTH(64), .WAIT(2)) dut  (.clk(clk), .rst(rst), .bus(b2.slave));
    dmem_responder #(.DEPTH(64), .WAIT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

    int checks = 0;
    int failures = 0;

    // model state, index 0 = WAIT 2 instance, index 1 = WAIT 0 instance
    logic [31:0] m_mem [2][64];
    bit          m_val [2][64];
    logic [15:0] m_led [2];
    bit          m_err [2];
    logic [31:0] m_ea  [2];

    function automatic int m_wait(int w);
        return (w == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] m_expect(int w, bit rd, bit wr, logic [31:0] a);
        if (!rd || wr) return 32'h0;
        if (a[1:0] == 2'b00 && a < 32'd256) return m_mem[w][a[7:2]];
        if (a == 32'h100) return {16'h0, m_led[w]};
        return 32'h0;
    endfunction

    function automatic void m_update(int w, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
        if (!(rd || wr)) return;
        if (a[1:0] == 2'b00 && a < 32'd256) begin
            if (wr) begin
                m_mem[w][a[7:2]] = d;
                m_val[w][a[7:2]] = 1'b1;
            end
        end else if (a == 32'h100) begin
            if (wr) m_led[w] = d[15:0];
        end else if (!m_err[w]) begin
            m_err[w] = 1'b1;
            m_ea[w]  = a;
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_led[i] = '0;
            m_err[i] = 1'b0;
            m_ea[i]  = '0;
        end
    endfunction

    task automatic drive(int w, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
        if (w == 1) begin
            b0.mem_read = rd; b0.mem_write = wr; b0.addr = a; b0.wdata = d;
        end else begin
            b2.mem_read = rd; b2.mem_write = wr; b2.addr = a; b2.wdata = d;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    // one access: returns stall cycles seen before completion and the completion rdata
    task automatic access(input int w, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, output int nst, output logic [31:0] rv);
        @(posedge clk); #1;
        drive(1 - w, 0, 0, 0, 0);
        drive(w, rd, wr, a, d);
        nst = 0;
        rv = 'x;
        forever begin
            @(negedge clk);
            if (((w == 1) ? b0.stall : b2.stall) === 1'b0) begin
                rv = (w == 1) ? b0.rdata : b2.rdata;
                break;
            end
            nst++;
            if (nst > 20) break;
        end
        m_update(w, rd, wr, a, d);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        m_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (b2.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b exp 0", b2.stall); end
        checks++; if (b2.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h exp 0", b2.rdata); end
        checks++; if (b2.led !== 16'h0) begin failures++; $display("FAIL reset_led got %h exp 0", b2.led); end
        checks++; if (b2.err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", b2.err); end
        checks++; if (b2.err_addr !== 32'h0) begin failures++; $display("FAIL reset_err_addr got %h exp 0", b2.err_addr); end
        checks++; if (b0.stall !== 1'b0 || b0.led !== 16'h0) begin failures++; $display("FAIL reset_w0 got stall %b led %h exp 0 0", b0.stall, b0.led); end
    endtask

    task automatic test_store_load();
        int nst;
        logic [31:0] rv;
        access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, nst, rv);
        checks++; if (nst !== 2) begin failures++; $display("FAIL store_stall_cycles got %0d exp 2", nst); end
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL store_rdata got %h exp 0", rv); end
        access(0, 1, 0, 32'h10, 32'h0, nst, rv);
        checks++; if (nst !== 2) begin failures++; $display("FAIL load_stall_cycles got %0d exp 2", nst); end
        checks++; if (rv !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_rdata got %h exp deadbeef", rv); end
        idle();
        checks++; if (b2.rdata !== 32'h0) begin failures++; $display("FAIL idle_rdata got %h exp 0", b2.rdata); end
    endtask

    task automatic test_zero_wait();
        int nst;
        logic [31:0] rv;
        access(1, 0, 1, 32'h4, 32'd5, nst, rv);
        checks++; if (nst !== 0) begin failures++; $display("FAIL w0_store_stall got %0d exp 0", nst); end
        access(1, 1, 0, 32'h4, 32'h0, nst, rv);
        checks++; if (nst !== 0) begin failures++; $display("FAIL w0_load_stall got %0d exp 0", nst); end
        checks++; if (rv !== 32'd5) begin failures++; $display("FAIL w0_load_rdata got %h exp 5", rv); end
        idle();
    endtask

    task automatic test_led();
        int nst;
        logic [31:0] rv;
        access(0, 0, 1, 32'h100, 32'h0001_ABCD, nst, rv);
        idle();
        checks++; if (b2.led !== 16'hABCD) begin failures++; $display("FAIL led_value got %h exp abcd", b2.led); end
        access(0, 1, 0, 32'h100, 32'h0, nst, rv);
        checks++; if (rv !== 32'h0000_ABCD) begin failures++; $display("FAIL led_load got %h exp 0000abcd", rv); end
        idle();
    endtask

    task automatic test_faults();
        int nst;
        logic [31:0] rv;
        access(0, 0, 1, 32'h0, 32'h1234_5678, nst, rv);
        access(0, 1, 0, 32'h6, 32'h0, nst, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL misaligned_rdata got %h exp 0", rv); end
        idle();
        checks++; if (b2.err !== 1'b1) begin failures++; $display("FAIL err_set got %b exp 1", b2.err); end
        checks++; if (b2.err_addr !== 32'h6) begin failures++; $display("FAIL err_addr_first got %h exp 6", b2.err_addr); end
        access(0, 0, 1, 32'h400, 32'hFFFF_FFFF, nst, rv);
        idle();
        checks++; if (b2.err_addr !== 32'h6) begin failures++; $display("FAIL err_addr_sticky got %h exp 6", b2.err_addr); end
        access(0, 1, 0, 32'h0, 32'h0, nst, rv);
        checks++; if (rv !== 32'h1234_5678) begin failures++; $display("FAIL oor_no_write got %h exp 12345678", rv); end
        idle();
    endtask

    task automatic test_both();
        int nst;
        logic [31:0] rv;
        access(0, 0, 1, 32'h8, 32'd7, nst, rv);
        access(0, 1, 1, 32'h8, 32'd9, nst, rv);
        checks++; if (rv !== 32'h0) begin failures++; $display("FAIL both_rdata got %h exp 0", rv); end
        access(0, 1, 0, 32'h8, 32'h0, nst, rv);
        checks++; if (rv !== 32'd9) begin failures++; $display("FAIL both_stored got %h exp 9", rv); end
        idle();
    endtask

    task automatic test_reset_mid();
        int nst;
        logic [31:0] rv;
        access(0, 0, 1, 32'h20, 32'h55, nst, rv);
        @(posedge clk); #1;
        drive(0, 0, 1, 32'h20, 32'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        #1;
        checks++; if (b2.led !== 16'h0) begin failures++; $display("FAIL mid_reset_led got %h exp 0", b2.led); end
        checks++; if (b2.err !== 1'b0) begin failures++; $display("FAIL mid_reset_err got %b exp 0", b2.err); end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        access(0, 1, 0, 32'h20, 32'h0, nst, rv);
        checks++; if (rv !== 32'h55) begin failures++; $display("FAIL mid_reset_dropped got %h exp 55", rv); end
        @(posedge clk); #1;
        drive(0, 0, 1, 32'h20, 32'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        nst = 0;
        forever begin
            @(negedge clk);
            if (b2.stall === 1'b0) break;
            nst++;
            if (nst > 20) break;
        end
        m_update(0, 0, 1, 32'h20, 32'hFF);
        checks++; if (nst !== 2) begin failures++; $display("FAIL restart_stall got %0d exp 2", nst); end
        access(0, 1, 0, 32'h20, 32'h0, nst, rv);
        checks++; if (rv !== 32'hFF) begin failures++; $display("FAIL restart_store got %h exp ff", rv); end
        idle();
    endtask

    task automatic test_random();
        int nst, w, kind;
        bit rd, wr;
        logic [31:0] a, d, rv, ex;
        for (int n = 0; n < 80; n++) begin
            w = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            d = $urandom;
            a = (kind == 6) ? 32'h100 :
                (kind == 7) ? {$urandom_range(0, 63), 2'b00} + 32'($urandom_range(1, 3)) :
                (kind == 8) ? 32'h1000 + {$urandom_range(0, 255), 2'b00} :
                32'({$urandom_range(0, 63), 2'b00});
            rd = $urandom_range(0, 1);
            wr = !rd || ($urandom_range(0, 7) == 0);
            if (rd && !wr && a < 32'd256 && a[1:0] == 2'b00 && !m_val[w][a[7:2]]) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            ex = m_expect(w, rd, wr, a);
            access(w, rd, wr, a, d, nst, rv);
            checks++; if (nst !== m_wait(w)) begin failures++; $display("FAIL rand_stall[%0d] got %0d exp %0d", n, nst, m_wait(w)); end
            checks++; if (rv !== ex) begin failures++; $display("FAIL rand_rdata[%0d] addr %h got %h exp %h", n, a, rv, ex); end
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        checks++; if (b2.led !== m_led[0] || b0.led !== m_led[1]) begin failures++; $display("FAIL rand_led got %h/%h exp %h/%h", b2.led, b0.led, m_led[0], m_led[1]); end
        checks++; if (b2.err !== m_err[0] || b0.err !== m_err[1]) begin failures++; $display("FAIL rand_err got %b/%b exp %b/%b", b2.err, b0.err, m_err[0], m_err[1]); end
        checks++; if (b2.err_addr !== m_ea[0] || b0.err_addr !== m_ea[1]) begin failures++; $display("FAIL rand_err_addr got %h/%h exp %h/%h", b2.err_addr, b0.err_addr, m_ea[0], m_ea[1]); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++)
                m_val[i][j] = 1'b0;
        test_reset();
        test_store_load();
        test_zero_wait();
        test_led();
        test_faults();
        test_both();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
